// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - load/store master for the single-port data memory
//
// Converts one MEM-stage request into memory read/write cycles. Loads issue a read,
// capture the doubleword one cycle later and extract/extend the addressed lanes.
// Doubleword stores write directly. Narrow stores read-modify-write the doubleword.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned accesses respond with rsp_err
// instead of being aligned down).
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_write, req_size,          store/load, 00 byte .. 11 dword,
//   req_signed, req_addr,         sign-extend narrow loads, byte address,
//   req_wdata                     store data (low req_size bytes used)
//   mem_read, mem_write,          registered memory strobes,
//   mem_address, mem_wdata        doubleword index and full write doubleword
//   mem_rdata                     memory data, valid the cycle after mem_read
//   rsp_valid, rsp_data, rsp_err  completion pulse, load result, misalign flag

`ifndef WORD
`define WORD 63:0
`endif

module dmem_access_ctrl #(
    parameter int IDX_BITS = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [1:0]   req_size,
    input  logic         req_signed,
    input  logic [`WORD] req_addr,
    input  logic [`WORD] req_wdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [`WORD] mem_address,
    output logic [`WORD] mem_wdata,
    input  logic [`WORD] mem_rdata,
    output logic         rsp_valid,
    output logic [`WORD] rsp_data,
    output logic         rsp_err
);

    typedef enum logic [2:0] {
        IDLE, LD_ISSUE, LD_CAPT, RMW_ISSUE, RMW_CAPT, ST_WRITE, RESP
    } state_t;

    state_t state, state_next;

    logic         write_q;
    logic [1:0]   size_q;
    logic         signed_q;
    logic [2:0]   off_q;
    logic [`WORD] wdata_q;
    logic         zero_rsp_q;
    logic [`WORD] load_q;

    logic         accept;
    logic         misaligned;
    logic         trap_now;
    logic [`WORD] idx_word;
    logic [5:0]   shamt;
    logic [`WORD] size_mask;
    logic [`WORD] shifted;
    logic         sign_bit;
    logic [`WORD] extracted;
    logic [`WORD] lane_mask;
    logic [`WORD] merged;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && (state == IDLE);

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b00: misaligned = 1'b0;
            2'b01: misaligned = req_addr[0];
            2'b10: misaligned = |req_addr[1:0];
            2'b11: misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign trap_now = misaligned;
`else
    // Without the trap, low address bits below the access size are simply
    // dropped by the lane-offset logic, which aligns the access down.
    assign trap_now = 1'b0;
`endif

    // Bits above IDX_BITS+2 are discarded so the index wraps over the memory.
    always_comb begin
        idx_word = '0;
        idx_word[IDX_BITS-1:0] = req_addr[IDX_BITS+2:3];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (trap_now)
                        state_next = RESP;
                    else if (!req_write)
                        state_next = LD_ISSUE;
                    else if (req_size == 2'b11)
                        state_next = ST_WRITE;
                    else
                        state_next = RMW_ISSUE;
                end
            end
            LD_ISSUE:  state_next = LD_CAPT;
            LD_CAPT:   state_next = RESP;
            RMW_ISSUE: state_next = RMW_CAPT;
            RMW_CAPT:  state_next = ST_WRITE;
            ST_WRITE:  state_next = RESP;
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Lane offset in bytes, naturally aligned to the latched access size.
    always_comb begin
        shamt     = 6'd0;
        size_mask = '1;
        case (size_q)
            2'b00: begin shamt = {off_q, 3'b000};         size_mask = 64'h0000_0000_0000_00FF; end
            2'b01: begin shamt = {off_q[2:1], 4'b0000};   size_mask = 64'h0000_0000_0000_FFFF; end
            2'b10: begin shamt = {off_q[2], 5'b00000};    size_mask = 64'h0000_0000_FFFF_FFFF; end
            default: begin shamt = 6'd0;                  size_mask = '1; end
        endcase
    end

    always_comb begin
        shifted  = mem_rdata >> shamt;
        sign_bit = 1'b0;
        case (size_q)
            2'b00:   sign_bit = shifted[7];
            2'b01:   sign_bit = shifted[15];
            2'b10:   sign_bit = shifted[31];
            default: sign_bit = 1'b0;
        endcase
        extracted = shifted & size_mask;
        if (signed_q && sign_bit)
            extracted = extracted | ~size_mask;
    end

    always_comb begin
        lane_mask = size_mask << shamt;
        merged    = (mem_rdata & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    end

    // Request fields are captured only at acceptance; inputs are ignored while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            off_q      <= 3'd0;
            wdata_q    <= '0;
            zero_rsp_q <= 1'b0;
        end else if (accept) begin
            write_q    <= req_write;
            size_q     <= req_size;
            signed_q   <= req_signed;
            off_q      <= req_addr[2:0];
            wdata_q    <= req_wdata;
            zero_rsp_q <= req_write || trap_now;
        end
    end

    // Strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            rsp_valid   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            load_q      <= '0;
        end else begin
            mem_read  <= (state_next == LD_ISSUE) || (state_next == RMW_ISSUE);
            mem_write <= (state_next == ST_WRITE);
            rsp_valid <= (state_next == RESP);
            if (accept)
                mem_address <= idx_word;
            if (accept && req_write && (req_size == 2'b11) && !trap_now)
                mem_wdata <= req_wdata;
            else if (state == RMW_CAPT)
                mem_wdata <= merged;
            if (state == LD_CAPT)
                load_q <= extracted;
        end
    end

    // Stores and trapped accesses report 0; the last load value is kept for later.
    assign rsp_data = ((state == RESP) && zero_rsp_q) ? '0 : load_q;

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_err <= 1'b0;
        else
            rsp_err <= accept && trap_now;
    end
`else
    assign rsp_err = 1'b0;
`endif

    logic unused_write_q;
    assign unused_write_q = write_q;

endmodule
